// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: runs ahead of decode, fills a circular instruction
// queue from a single-cycle instruction memory and flushes on redirect.
`timescale 1ns/1ps
module prefetch_unit #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [XLEN-1:0]            imemAddress,
    output logic                       imemRequest,
    input  logic                       imemReady,
    input  logic [31:0]                imemData,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirectTarget,
    input  logic                       stall,
    output logic                       idValid,
    output logic [31:0]                idInstruction,
    output logic [XLEN-1:0]            idProgramCounter,
    output logic [$clog2(DEPTH+1)-1:0] queueCount
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [31:0]      NOP        = 32'h00000013;

    logic [XLEN-1:0]  fetch_pc;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic             push;
    logic             pop;

    // Redirect targets are word aligned, so the low two bits are dropped.
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^redirectTarget[1:0];

    assign imemAddress = fetch_pc;
    assign imemRequest = !rst && !redirect && (count < FULL_COUNT);
    assign push        = imemRequest && imemReady;
    assign idValid     = (count != '0);
    assign pop         = !rst && idValid && !stall && !redirect;
    assign queueCount  = count;

    assign idInstruction    = idValid ? instr_mem[head_ptr] : NOP;
    assign idProgramCounter = idValid ? pc_mem[head_ptr]    : '0;

    // Control state: fetch PC, queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirectTarget[XLEN-1:2], 2'b00};
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + XLEN'(4);
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage is never reset; idValid masks stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_ptr]    <= fetch_pc;
            instr_mem[tail_ptr] <= imemData;
        end
    end

endmodule
